// File: rtl/crossbar_buffered.sv
// crossbar_buffered
//   Router crossbar that switches granted flits into a per-output FIFO.
//   Each output has a valid/ready handshake. An error monitor records the
//   first grant conflict or FIFO overflow in a sticky trigger and trace word.
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   granted_dest_port_all  : per input, a (P-1)-bit grant vector that excludes the input's own port
//   flit_in_all            : per-input flits, Fw bits each
//   flit_out_all           : head flit of each output FIFO, zero when the output is not valid
//   flit_out_valid_all     : output FIFO is non-empty
//   out_ready_all          : downstream accepts the head flit this cycle
//   out_full_all           : output FIFO holds DEPTH entries
//   trig_clr               : clears trigger and trace and re-arms capture
//   trigger, trace         : sticky error flag and capture word of the first error

module crossbar_buffered_fifo #(
   parameter int W     = 38,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push_req,
   input  logic [W-1:0] i_din,
   input  logic         i_ready,
   output logic [W-1:0] o_dout,
   output logic         o_valid,
   output logic         o_full,
   output logic         o_ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_pop, w_push;

   assign o_valid = (r_cnt != '0);
   assign o_full  = (r_cnt == FULL_CNT);
   assign w_pop   = o_valid & i_ready;
   // When full, a same-cycle pop frees the slot the push needs.
   assign w_push  = i_push_req & (~o_full | w_pop);
   assign o_ovf   = i_push_req & o_full & ~w_pop;
   assign o_dout  = o_valid ? r_mem[r_rp] : '0;

   // Storage is deliberately left unreset; the output is masked by valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

module crossbar_buffered #(
   parameter int V     = 4,
   parameter int P     = 5,
   parameter int Fpay  = 32,
   parameter int DEPTH = 2,
   localparam int Fw   = 2 + V + Fpay
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [P*(P-1)-1:0]   granted_dest_port_all,
   input  logic [P*Fw-1:0]      flit_in_all,
   output logic [P*Fw-1:0]      flit_out_all,
   output logic [P-1:0]         flit_out_valid_all,
   input  logic [P-1:0]         out_ready_all,
   output logic [P-1:0]         out_full_all,
   input  logic                 trig_clr,
   output logic                 trigger,
   output logic [31:0]          trace
);
   logic [P-1:0][P-1:0]  w_req;   // [output][input]
   logic [P-1:0][Fw-1:0] w_win;
   logic [P-1:0][Fw-1:0] w_dout;
   logic [P-1:0]         w_conf, w_ovf, w_err;
   logic [7:0]           w_err_idx;
   logic [15:0]          r_cyc;

   // Undo the self-excluding grant encoding: bit k of input i means output k
   // when k<i, otherwise output k+1.
   always_comb begin
      w_req = '0;
      for (int o = 0; o < P; o++)
         for (int i = 0; i < P; i++)
            if (o < i)      w_req[o][i] = granted_dest_port_all[i*(P-1) + o];
            else if (o > i) w_req[o][i] = granted_dest_port_all[i*(P-1) + o - 1];
   end

   // Lowest-index requester wins. The descending scan leaves the lowest one last.
   always_comb begin
      w_win = '0;
      for (int o = 0; o < P; o++)
         for (int i = P-1; i >= 0; i--)
            if (w_req[o][i]) w_win[o] = flit_in_all[i*Fw +: Fw];
   end

   genvar o;
   generate
      for (o = 0; o < P; o++) begin : g_out
         // More than one requester if clearing the lowest set bit leaves any bit set.
         assign w_conf[o] = |(w_req[o] & (w_req[o] - 1'b1));
         assign w_err[o]  = w_conf[o] | w_ovf[o];
         assign flit_out_all[o*Fw +: Fw] = w_dout[o];

         crossbar_buffered_fifo #(.W(Fw), .DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .i_push_req (|w_req[o]),
            .i_din      (w_win[o]),
            .i_ready    (out_ready_all[o]),
            .o_dout     (w_dout[o]),
            .o_valid    (flit_out_valid_all[o]),
            .o_full     (out_full_all[o]),
            .o_ovf      (w_ovf[o])
         );
      end
   endgenerate

   always_comb begin
      w_err_idx = '0;
      for (int k = P-1; k >= 0; k--)
         if (w_err[k]) w_err_idx = 8'(k);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cyc   <= '0;
         trigger <= 1'b0;
         trace   <= '0;
      end else begin
         r_cyc <= r_cyc + 1'b1;
         if (trig_clr) begin
            // A clear beats an error in the same cycle.
            trigger <= 1'b0;
            trace   <= '0;
         end else if (!trigger && (|w_err)) begin
            trigger <= 1'b1;
            trace   <= {|w_ovf, |w_conf, 6'd0, w_err_idx, r_cyc};
         end
      end
   end
endmodule

// File: doc/crossbar_buffered.md
# crossbar_buffered

Parametrised router crossbar with a per-output FIFO stage, a valid/ready handshake on every output, and an error monitor with a debug trigger. It sits between the switch allocator and the output ports of a router. Granted flits are switched combinationally and captured in a per-output FIFO of configurable depth. A downstream stall therefore does not have to be resolved in the allocation cycle. Grant conflicts and FIFO overflows are detected, resolved deterministically, and reported through `trigger` and `trace`.

## Interface
- `V`, 4: VCs per port; sets flit width.
- `P`, 5: router port count, 2..16.
- `Fpay`, 32: payload width; `Fw = 2+V+Fpay`.
- `DEPTH`, 2: entries per output FIFO; power of two, ≥2.
- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `granted_dest_port_all` input P*(P-1): per input i, a (P-1)-bit grant vector (excludes self); bit k → output k if k<i, else k+1.
- `flit_in_all` input P*Fw: flit of input i at `[(i+1)*Fw-1 : i*Fw]`.
- `flit_out_all` output P*Fw: head flit of each output FIFO; all-zero when that output is not valid.
- `flit_out_valid_all` output P: output o FIFO non-empty.
- `out_ready_all` input P: downstream of output o accepts this cycle.
- `out_full_all` output P: FIFO o holds DEPTH entries (registered), for the allocator.
- `trig_clr` input 1: clears `trigger` and `trace`, re-arms capture.
- `trigger` output 1: sticky error flag.
- `trace` output 32: capture word of the first error since reset or `trig_clr`.

## Operation
- Column gather per output o:
  - the request set is every input i whose decoded grant targets o;
  - the winner is the lowest-index requester, and its flit is written into FIFO o.
- Conflict: two or more requesters for one output in the same cycle.
  - The lowest-index requester's flit is written; the rest are dropped.
  - The conflict error is raised for o.
- Push occurs when the request set is non-empty and the FIFO can accept.
  - Acceptance condition: `count<DEPTH`, or a pop occurs in the same cycle.
- Pop occurs when `flit_out_valid_all[o] & out_ready_all[o]`.
- Overflow: a push with `count==DEPTH` and no pop in the same cycle.
  - The flit is dropped; FIFO state is unchanged.
  - The overflow error is raised for o.
- Push and pop in the same cycle:
  - count is unchanged;
  - the head advances and the new flit goes to the tail;
  - with DEPTH entries full, the push is accepted.
- Counts are `log2(DEPTH)+1` bits. Read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
- Cycle counter: 16-bit, free-running from 0 after reset, wraps 0xFFFF→0.
- Error capture happens when `trigger` is 0 and any error occurs this cycle:
  - `trigger` ← 1;
  - `trace[31:30]` ← code: 01 conflict, 10 overflow, 11 both;
  - `trace[29:24]` ← 0;
  - `trace[23:16]` ← binary index of the lowest erroneous output;
  - `trace[15:0]` ← cycle counter value.
  - Later errors do not alter `trace` until `trig_clr`.
- `trig_clr` with an error in the same cycle: the clear wins, and that error is not captured.

## Timing
- Reset values:
  - FIFO counts and pointers 0;
  - `flit_out_valid_all` 0, `flit_out_all` 0, `out_full_all` 0;
  - `trigger` 0, `trace` 0, cycle counter 0.
  - FIFO storage is not reset; outputs are masked by valid.
- Reset asserted mid-operation flushes all FIFOs on the next edge; in-flight flits are lost.
- Grant-to-output latency: a grant sampled at edge n gives `flit_out_valid_all[o]`=1 with that flit from cycle n+1.
- Throughput: with `out_ready` held high, one flit per cycle per output, sustained.
- `out_full_all` reflects the count after the edge; it does not look ahead to a same-cycle pop.
- `trigger`/`trace` update one cycle after the offending grant.

## Test plan
- Single flit:
  - stimulus: P=5, input 0 grants output 2 (vector 4'b0010) with flit 0x…A5, `out_ready`=1;
  - required: next cycle `flit_out_valid_all`=5'b00100 with that flit on slice 2; following cycle valid is 0 and the slice is 0.
- Backpressure and full:
  - stimulus: DEPTH=2, `out_ready[3]`=0, three consecutive grants to output 3;
  - required: `out_full_all[3]`=1 after the second grant; the third grant is dropped; `trigger`=1; `trace[31:30]`=10, `trace[23:16]`=3.
- Push/pop while full:
  - stimulus: FIFO 1 full, `out_ready[1]`=1, and a grant in the same cycle;
  - required: no overflow, count stays 2, FIFO order preserved.
- Conflict:
  - stimulus: inputs 1 and 4 both grant output 0 in one cycle;
  - required: input 1's flit appears; `trace[31:30]`=01, `trace[23:16]`=0; `trace[15:0]` equals the cycle count.
- Trigger sticky and clear:
  - stimulus: a second error after capture, then `trig_clr`, then an overflow in the cycle after the clear;
  - required: `trace` is unchanged by the second error, reads 0 after the clear, and captures the new event afterward.
- Reset mid-stream:
  - stimulus: assert `reset` with all FIFOs non-empty;
  - required: next cycle all valids, fulls, `trigger` and `trace` are 0.
